// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one RV32I load/store per transaction,
// a fixed number of wait states, then a registered valid/ready response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             req_ready_d, rsp_valid_d, rsp_err_d;
  logic [31:0]      rsp_rdata_d;

  logic [31:0]      addr_q, wdata_q;
  logic             write_q;
  logic [2:0]       funct3_q;

  logic             latch_c;
  logic             mem_we_c;
  logic             err_c;
  logic [IDX_W-1:0] idx_c;
  logic [31:0]      mem_word_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [31:0]      load_data_c;
  logic [3:0]       be_c;
  logic [31:0]      store_word_c;

  logic [31:0]      mem [DEPTH_WORDS];

  assign idx_c      = addr_q[IDX_W+1:2];
  assign mem_word_c = mem[idx_c];

  // Error detection on the latched request: illegal funct3, misalignment, range
  always_comb begin
    logic legal;
    logic misalign;
    logic range;
    if (write_q) legal = funct3_q inside {3'b000, 3'b001, 3'b010};
    else         legal = funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misalign = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
               ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    range    = 32'(addr_q[31:2]) >= DEPTH_WORDS;
    err_c    = !legal || misalign || range;
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    byte_c = 8'h00;
    case (addr_q[1:0])
      2'd0:    byte_c = mem_word_c[7:0];
      2'd1:    byte_c = mem_word_c[15:8];
      2'd2:    byte_c = mem_word_c[23:16];
      default: byte_c = mem_word_c[31:24];
    endcase
    half_c = addr_q[1] ? mem_word_c[31:16] : mem_word_c[15:0];
    case (funct3_q)
      3'b000:  load_data_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  load_data_c = {{16{half_c[15]}}, half_c};
      3'b010:  load_data_c = mem_word_c;
      3'b100:  load_data_c = {24'h000000, byte_c};
      3'b101:  load_data_c = {16'h0000, half_c};
      default: load_data_c = 32'h0000_0000;
    endcase
  end

  // Store byte enables and lane-replicated write data (little-endian)
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        be_c         = 4'b0001 << addr_q[1:0];
        store_word_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_c         = addr_q[1] ? 4'b1100 : 4'b0011;
        store_word_c = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c         = 4'b1111;
        store_word_c = wdata_q;
      end
    endcase
  end

  // Next-state and next-output logic for IDLE -> WAIT -> RESP
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    req_ready_d = req_ready;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    latch_c     = 1'b0;
    mem_we_c    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          latch_c     = 1'b1;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          req_ready_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          mem_we_c    = write_q && !err_c;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_c;
          rsp_rdata_d = (write_q || err_c) ? 32'h0000_0000 : load_data_c;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0000_0000;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

  // Request capture at the accepting edge; later input changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= 32'h0000_0000;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      wdata_q  <= 32'h0000_0000;
    end else if (latch_c) begin
      addr_q   <= req_addr;
      write_q  <= req_write;
      funct3_q <= req_funct3;
      wdata_q  <= req_wdata;
    end
  end

  // Storage write with per-byte enables; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[idx_c][8*b +: 8] <= store_word_c[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (2, 0 and 5 wait states) checked
// against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr   [3];
  logic        req_write  [3];
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_wdata  [3];
  logic        rsp_valid  [3];
  logic        rsp_ready  [3];
  logic [31:0] rsp_rdata  [3];
  logic        rsp_err    [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit [7:0] bmem [3][4*DEPTH];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_CYCLES(g == 0 ? 2 : (g == 1 ? 0 : 5))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_addr   (req_addr[g]),
      .req_write  (req_write[g]),
      .req_funct3 (req_funct3[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input int u);
    return (u == 0) ? 2 : ((u == 1) ? 0 : 5);
  endfunction

  // Reference: byte-addressed memory, access size 1/2/4 from funct3[1:0]
  task automatic model(input int u, input logic [31:0] a, input logic w,
                       input logic [2:0] f3, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e);
    int unsigned sz;
    bit legal;
    logic [31:0] v;
    logic [31:0] mask;
    rd = 32'h0;
    e  = 1'b0;
    legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz = 1 << f3[1:0];
    if (!legal) e = 1'b1;
    else if ((a % sz) != 0) e = 1'b1;
    else if ((a / 4) >= DEPTH) e = 1'b1;
    if (!e) begin
      if (w) begin
        for (int k = 0; k < int'(sz); k++) bmem[u][a + k] = 8'(wd >> (8 * k));
      end else begin
        v = 32'h0;
        for (int k = 0; k < int'(sz); k++) v = v | (32'(bmem[u][a + k]) << (8 * k));
        if (sz < 4 && !f3[2] && (((v >> (8 * sz - 1)) & 32'h1) == 32'h1)) begin
          mask = (32'h1 << (8 * sz)) - 32'h1;
          v = v | ~mask;
        end
        rd = v;
      end
    end
  endtask

  task automatic send(input int u, input logic [31:0] a, input logic w,
                      input logic [2:0] f3, input logic [31:0] wd, output int acc);
    int n = 0;
    while (req_ready[u] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (req_ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout u%0d: req_ready=%b required 1", u, req_ready[u]);
    end
    req_valid[u] = 1'b1; req_addr[u] = a; req_write[u] = w;
    req_funct3[u] = f3; req_wdata[u] = wd;
    @(posedge clk); #1;
    acc = cyc;
    req_valid[u]  = 1'b0;
    req_addr[u]   = $urandom; req_write[u] = 1'($urandom);
    req_funct3[u] = 3'($urandom); req_wdata[u] = $urandom;
  endtask

  task automatic wait_rsp(input int u, output int lat);
    lat = 0;
    while (rsp_valid[u] !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  // Full transaction with rsp_ready held high, checked against the model
  task automatic do_txn(input int u, input string tag, input logic [31:0] a, input logic w,
                        input logic [2:0] f3, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int acc);
    logic [31:0] exp_rd;
    logic exp_e;
    int lat;
    model(u, a, w, f3, wd, exp_rd, exp_e);
    rsp_ready[u] = 1'b1;
    send(u, a, w, f3, wd, acc);
    checks++;
    if (req_ready[u] !== 1'b0) begin
      errors++; $display("FAIL %s busy_ready: got %b required 0", tag, req_ready[u]);
    end
    wait_rsp(u, lat);
    checks++;
    if (lat != wc(u) + 1) begin
      errors++; $display("FAIL %s latency: got %0d required %0d", tag, lat, wc(u) + 1);
    end
    checks++;
    if (rsp_err[u] !== exp_e) begin
      errors++; $display("FAIL %s err: got %b required %b", tag, rsp_err[u], exp_e);
    end
    checks++;
    if (rsp_rdata[u] !== exp_rd) begin
      errors++; $display("FAIL %s rdata: got %h required %h", tag, rsp_rdata[u], exp_rd);
    end
    rd = rsp_rdata[u];
    e  = rsp_err[u];
    @(posedge clk); #1;
    checks++;
    if (rsp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL %s release: rsp_valid=%b req_ready=%b required 0/1", tag, rsp_valid[u], req_ready[u]);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++; $display("FAIL %s: got %h required %h", tag, got, req);
    end
  endtask

  task automatic test_reset();
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (req_ready[u] !== 1'b1 || rsp_valid[u] !== 1'b0 || rsp_rdata[u] !== 32'h0 || rsp_err[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset u%0d: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
                 u, req_ready[u], rsp_valid[u], rsp_rdata[u], rsp_err[u]);
      end
    end
  endtask

  task automatic test_sw_lw();
    logic [31:0] rd; logic e; int acc;
    do_txn(0, "sw_10", 32'h10, 1'b1, 3'b010, 32'hDEAD_BEEF, rd, e, acc);
    expect_val("sw_10_rdata", rd, 32'h0);
    do_txn(0, "lw_10", 32'h10, 1'b0, 3'b010, 32'h0, rd, e, acc);
    expect_val("lw_10_value", rd, 32'hDEAD_BEEF);
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic e; int acc;
    do_txn(0, "sw_20", 32'h20, 1'b1, 3'b010, 32'h1122_3344, rd, e, acc);
    do_txn(0, "sb_21", 32'h21, 1'b1, 3'b000, 32'h0000_00AA, rd, e, acc);
    do_txn(0, "lw_20", 32'h20, 1'b0, 3'b010, 32'h0, rd, e, acc);
    expect_val("lw_20_after_sb", rd, 32'h1122_AA44);
    do_txn(0, "lb_21", 32'h21, 1'b0, 3'b000, 32'h0, rd, e, acc);
    expect_val("lb_21_value", rd, 32'hFFFF_FFAA);
    do_txn(0, "lbu_21", 32'h21, 1'b0, 3'b100, 32'h0, rd, e, acc);
    expect_val("lbu_21_value", rd, 32'h0000_00AA);
    do_txn(0, "sh_22", 32'h22, 1'b1, 3'b001, 32'h0000_8001, rd, e, acc);
    do_txn(0, "lh_22", 32'h22, 1'b0, 3'b001, 32'h0, rd, e, acc);
    expect_val("lh_22_value", rd, 32'hFFFF_8001);
    do_txn(0, "lhu_22", 32'h22, 1'b0, 3'b101, 32'h0, rd, e, acc);
    expect_val("lhu_22_value", rd, 32'h0000_8001);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int acc;
    do_txn(0, "lw_13", 32'h13, 1'b0, 3'b010, 32'h0, rd, e, acc);
    expect_val("lw_13_err", 32'(e), 32'h1);
    do_txn(0, "sw_04", 32'h04, 1'b1, 3'b010, 32'hCAFE_F00D, rd, e, acc);
    do_txn(0, "sh_05", 32'h05, 1'b1, 3'b001, 32'h0000_5555, rd, e, acc);
    expect_val("sh_05_err", 32'(e), 32'h1);
    do_txn(0, "lw_04", 32'h04, 1'b0, 3'b010, 32'h0, rd, e, acc);
    expect_val("lw_04_unchanged", rd, 32'hCAFE_F00D);
    do_txn(0, "lw_oor", 32'h0000_1000, 1'b0, 3'b010, 32'h0, rd, e, acc);
    expect_val("lw_oor_err", 32'(e), 32'h1);
    do_txn(0, "ld_f3_011", 32'h10, 1'b0, 3'b011, 32'h0, rd, e, acc);
    expect_val("ld_f3_011_err", 32'(e), 32'h1);
    do_txn(0, "st_f3_100", 32'h10, 1'b1, 3'b100, 32'h0, rd, e, acc);
    expect_val("st_f3_100_err", 32'(e), 32'h1);
  endtask

  task automatic test_backpressure();
    int acc, lat;
    rsp_ready[0] = 1'b0;
    send(0, 32'h10, 1'b0, 3'b010, 32'h0, acc);
    wait_rsp(0, lat);
    expect_val("bp_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEAD_BEEF || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b rdata=%h err=%b ready=%b required 1/deadbeef/0/0",
                 i, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0]);
      end
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b required 0/1", rsp_valid[0], req_ready[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, wd; logic e; int acc, prev;
    for (int u = 1; u < 3; u++) begin
      prev = -1;
      for (int i = 0; i < 4; i++) begin
        wd = $urandom;
        do_txn(u, "b2b_sw", 32'h100 + 32'(4 * i), 1'b1, 3'b010, wd, rd, e, acc);
        if (prev >= 0) expect_val("b2b_spacing_sw", 32'(acc - prev), 32'(wc(u) + 3));
        prev = acc;
        do_txn(u, "b2b_lw", 32'h100 + 32'(4 * i), 1'b0, 3'b010, 32'h0, rd, e, acc);
        expect_val("b2b_spacing_lw", 32'(acc - prev), 32'(wc(u) + 3));
        expect_val("b2b_lw_value", rd, wd);
        prev = acc;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd; logic e; int acc, lat;
    do_txn(0, "ar_clear", 32'h40, 1'b1, 3'b010, 32'h0, rd, e, acc);
    rsp_ready[0] = 1'b1;
    send(0, 32'h40, 1'b1, 3'b010, 32'h1234_5678, acc);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL ar_wait_outputs: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
               req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_txn(0, "ar_lw_40", 32'h40, 1'b0, 3'b010, 32'h0, rd, e, acc);
    expect_val("ar_lw_40_value", rd, 32'h0);
    rsp_ready[0] = 1'b0;
    send(0, 32'h10, 1'b0, 3'b010, 32'h0, acc);
    wait_rsp(0, lat);
    expect_val("ar_resp_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL ar_resp_outputs: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
               req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready[0] = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] rd, a; logic e, w; logic [2:0] f3; int acc;
    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < 32; i++)
        do_txn(u, "rnd_fill", 32'(4 * i), 1'b1, 3'b010, $urandom, rd, e, acc);
      for (int i = 0; i < 40; i++) begin
        a  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_1000) : 32'($urandom_range(0, 127));
        w  = 1'($urandom);
        f3 = 3'($urandom_range(0, 7));
        do_txn(u, "rnd_op", a, w, f3, $urandom, rd, e, acc);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      req_valid[u] = 1'b0; req_addr[u] = 32'h0; req_write[u] = 1'b0;
      req_funct3[u] = 3'b000; req_wdata[u] = 32'h0; rsp_ready[u] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_sw_lw();
    test_subword();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked data-memory responder: the slave end of the core's load/store interface, for the multi-cycle and pipelined cores that replace the combinational DMEM.
- Accepts one load/store request per transaction and inserts a configurable number of wait states.
- Performs RV32I sub-word load/store formatting (LB/LH/LW/LBU/LHU, SB/SH/SW) internally.
- Returns read data or an error flag through a valid/ready response channel.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words of storage; the word index is req_addr[31:2].
WAIT_CYCLES, 2, wait states between request acceptance and the memory access (0..15).

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_addr  input  32  byte address
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I load/store funct3
req_wdata  input  32  store data; low byte/half used for SB/SH
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts the response
rsp_rdata  output  32  formatted load data; 0 for stores and on error
rsp_err  output  1  misaligned, out-of-range, or illegal funct3

Behaviour:
- Reset (async, active-high): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Storage contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge: latch addr, write, funct3 and wdata; load counter with WAIT_CYCLES; go to WAIT.
- WAIT:
  - req_ready=0. Counter decrements each edge.
  - At the edge where counter==0: perform the access, register rsp_rdata and rsp_err, set rsp_valid=1, go to RESP.
  - Latency: rsp_valid rises on the (WAIT_CYCLES+1)th rising edge after the accepting edge. With WAIT_CYCLES=0, that is the next edge.
- RESP:
  - req_ready=0. rsp_valid, rsp_rdata and rsp_err hold stable until rsp_ready=1 at an edge.
  - On that edge: rsp_valid=0, go to IDLE.
  - No same-cycle accept of a new request; minimum spacing between accepts is WAIT_CYCLES+3 cycles.
- Input changes after acceptance have no effect; all fields are taken from the latched copy.
- Error conditions (checked on the latched request):
  - funct3 not in {000,001,010,100,101} for loads, or not in {000,001,010} for stores.
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - addr[31:2] >= DEPTH_WORDS.
- On error: no storage write, rsp_err=1, rsp_rdata=0. The error response still takes the full latency.
- Stores:
  - Byte enables come from addr[1:0]. SB writes the byte at lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}; SW writes all four.
  - Little-endian. Unselected bytes are unchanged.
  - rsp_rdata=0, rsp_err=0.
- Loads:
  - LB/LH sign-extend; LBU/LHU zero-extend the selected lane(s); LW returns the full word.
- Reset mid-transaction (WAIT or RESP): the transaction is abandoned and outputs take reset values.
  - A store in WAIT whose access edge has not occurred is not performed.
  - A store already performed remains in storage.
- req_valid in WAIT/RESP is ignored (req_ready=0); the requester must hold it until accepted.

Test Plan:
- SW then LW, WAIT_CYCLES=2: store 0xDEADBEEF to addr 0x10 accepted at edge 0 -> rsp_valid at edge 3 with rsp_err=0, rsp_rdata=0. Then LW 0x10 -> rsp_rdata=0xDEADBEEF.
- Sub-word store and signed/unsigned loads on word 0x20 initialised to 0x11223344:
  - SB 0xAA to 0x21 -> LW 0x20 = 0x1122AA44.
  - LB 0x21 = 0xFFFFFFAA; LBU 0x21 = 0x000000AA.
  - SH 0x8001 to 0x22 -> LH 0x22 = 0xFFFF8001; LHU 0x22 = 0x00008001.
- Errors:
  - LW 0x13 -> rsp_err=1, rsp_rdata=0.
  - SH to 0x05 -> rsp_err=1, and word 0x04 is unchanged on re-read.
  - LW 0x00001000 with DEPTH_WORDS=1024 -> rsp_err=1.
  - Load with funct3=011 -> rsp_err=1.
- Response backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0. Raise rsp_ready -> rsp_valid=0 and req_ready=1 the next cycle.
- Latency sweep WAIT_CYCLES=0 and 5: back-to-back requests with rsp_ready tied 1 -> responses one and six edges after accept respectively; accepts spaced 3 and 8 cycles.
- Async reset mid-transaction: assert rst asynchronously in WAIT during an SW of 0x12345678 to 0x40 (prior content 0x0) -> outputs reset immediately without a clock edge. After release, LW 0x40 returns 0x00000000.
